// File: rtl/hazard_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sched
//  Description : Pipeline hazard controller for the five-stage core. Drives
//                PC / PS1..PS4 enables and PS1/PS2 bubble clears, resolving
//                data-memory busy, halting syscall, branch mispredict and
//                load-use by fixed priority. Holds a RUN/DRAIN/HALT machine
//                and wrapping performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_sched #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_r_datamem,
  input  logic             ex_w_en,
  input  logic [4:0]       ex_req_w,
  input  logic             mispredict,
  input  logic             syscall_halt,
  input  logic             dm_busy,
  input  logic             resume,
  output logic             pc_en,
  output logic             ps1_en,
  output logic             ps2_en,
  output logic             ps3_en,
  output logic             ps4_en,
  output logic             ps1_clear,
  output logic             ps2_clear,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // The counter is loaded with one less than the drain length so that the
  // cycle seeing zero is the last drain cycle.
  localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu;

  // Load in EX whose destination is a live source of the ID instruction.
  assign lu = ex_r_datamem & ex_w_en & (ex_req_w != 5'd0) &
              ((id_use_rs & (id_rs == ex_req_w)) |
               (id_use_rt & (id_rt == ex_req_w)));

  // Next-state, counter update and combinational control decode.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    lu_cnt_d    = lu_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    cycle_cnt_d = (state_q != S_HALT) ? cycle_cnt_q + CNT_ONE : cycle_cnt_q;
    pc_en       = 1'b0;
    ps1_en      = 1'b0;
    ps2_en      = 1'b0;
    ps3_en      = 1'b0;
    ps4_en      = 1'b0;
    ps1_clear   = 1'b0;
    ps2_clear   = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_RUN: begin
        if (dm_busy) begin
          // Whole pipe freezes while memory is busy.
          stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else if (syscall_halt) begin
          // Syscall moves on to MEM; younger instructions are squashed.
          ps1_clear = 1'b1;
          ps2_clear = 1'b1;
          ps3_en    = 1'b1;
          ps4_en    = 1'b1;
          drain_d   = DRAIN_LOAD;
          state_d   = S_DRAIN;
        end else if (mispredict) begin
          // PC takes the corrected target; wrong-path work is squashed.
          pc_en       = 1'b1;
          ps1_clear   = 1'b1;
          ps2_clear   = 1'b1;
          ps3_en      = 1'b1;
          ps4_en      = 1'b1;
          flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else if (lu) begin
          // Hold PC and IF/ID, push a bubble into EX.
          ps2_clear = 1'b1;
          ps3_en    = 1'b1;
          ps4_en    = 1'b1;
          lu_cnt_d  = lu_cnt_q + CNT_ONE;
        end else begin
          pc_en  = 1'b1;
          ps1_en = 1'b1;
          ps2_en = 1'b1;
          ps3_en = 1'b1;
          ps4_en = 1'b1;
        end
      end

      S_DRAIN: begin
        if (dm_busy) begin
          stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
          // Front end holds, back end retires the syscall.
          ps2_clear = 1'b1;
          ps3_en    = 1'b1;
          ps4_en    = 1'b1;
          if (drain_q == 4'd0) begin
            state_d = S_HALT;
          end else begin
            drain_d = drain_q - 4'd1;
          end
        end
      end

      S_HALT: begin
        halted = 1'b1;
        if (resume) begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    // Outputs are quiet while reset is held.
    if (!rst_n) begin
      pc_en     = 1'b0;
      ps1_en    = 1'b0;
      ps2_en    = 1'b0;
      ps3_en    = 1'b0;
      ps4_en    = 1'b0;
      ps1_clear = 1'b0;
      ps2_clear = 1'b0;
      halted    = 1'b0;
    end
  end

  // State, drain counter and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      drain_q     <= 4'd0;
      cycle_cnt_q <= '0;
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cycle_cnt_q <= cycle_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cycle_cnt     = cycle_cnt_q;
  assign load_use_cnt  = lu_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign mem_stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_sched
//  Description : Self-checking bench for hazard_sched (DRAIN_CYCLES=2,
//                CNT_W=4) against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_sched;

  localparam int DC = 2;
  localparam int CW = 4;
  localparam int MOD = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_req_w;
  logic id_use_rs, id_use_rt, ex_r_datamem, ex_w_en;
  logic mispredict, syscall_halt, dm_busy, resume;
  logic pc_en, ps1_en, ps2_en, ps3_en, ps4_en, ps1_clear, ps2_clear, halted;
  logic [CW-1:0] cycle_cnt, load_use_cnt, flush_cnt, mem_stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=running, 1=draining, 2=halted.
  int m_phase;
  int m_left;
  int m_cyc, m_lu, m_flush, m_stall;

  hazard_sched #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_r_datamem(ex_r_datamem), .ex_w_en(ex_w_en), .ex_req_w(ex_req_w),
    .mispredict(mispredict), .syscall_halt(syscall_halt), .dm_busy(dm_busy),
    .resume(resume),
    .pc_en(pc_en), .ps1_en(ps1_en), .ps2_en(ps2_en), .ps3_en(ps3_en),
    .ps4_en(ps4_en), .ps1_clear(ps1_clear), .ps2_clear(ps2_clear),
    .halted(halted), .cycle_cnt(cycle_cnt), .load_use_cnt(load_use_cnt),
    .flush_cnt(flush_cnt), .mem_stall_cnt(mem_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit ref_lu();
    return ex_r_datamem && ex_w_en && (ex_req_w != 0) &&
           ((id_use_rs && id_rs == ex_req_w) || (id_use_rt && id_rt == ex_req_w));
  endfunction

  // Expected {pc,ps1,ps2,ps3,ps4,clr1,clr2,halted}.
  function automatic logic [7:0] exp_ctrl();
    if (!rst_n) return 8'b00000_00_0;
    if (m_phase == 2) return 8'b00000_00_1;
    if (dm_busy) return 8'b00000_00_0;
    if (m_phase == 1) return 8'b00011_01_0;
    if (syscall_halt) return 8'b00011_11_0;
    if (mispredict) return 8'b10011_11_0;
    if (ref_lu()) return 8'b00011_01_0;
    return 8'b11111_00_0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = 0;
    m_cyc = 0; m_lu = 0; m_flush = 0; m_stall = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    if (m_phase != 2) m_cyc = (m_cyc + 1) % MOD;
    case (m_phase)
      0: begin
        if (dm_busy) m_stall = (m_stall + 1) % MOD;
        else if (syscall_halt) begin m_phase = 1; m_left = DC; end
        else if (mispredict) m_flush = (m_flush + 1) % MOD;
        else if (ref_lu()) m_lu = (m_lu + 1) % MOD;
      end
      1: begin
        if (dm_busy) m_stall = (m_stall + 1) % MOD;
        else begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
      end
      default: if (resume) m_phase = 0;
    endcase
  endtask

  task automatic check_all();
    chk("ctrl", {24'd0, pc_en, ps1_en, ps2_en, ps3_en, ps4_en, ps1_clear, ps2_clear, halted},
        {24'd0, exp_ctrl()});
    chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
    chk("load_use_cnt", 32'(load_use_cnt), 32'(m_lu));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    chk("mem_stall_cnt", 32'(mem_stall_cnt), 32'(m_stall));
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_r_datamem = 1'b0; ex_w_en = 1'b0; ex_req_w = 5'd0;
    mispredict = 1'b0; syscall_halt = 1'b0; dm_busy = 1'b0; resume = 1'b0;
  endtask

  // Inputs are already driven; check mid-cycle, then advance one edge.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load_use_pattern(input logic [4:0] rd);
    ex_r_datamem = 1'b1; ex_w_en = 1'b1; ex_req_w = rd;
    id_rs = 5'd5; id_use_rs = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load-use, then the same with r0 as destination (no stall).
    load_use_pattern(5'd5); step();
    chk("lu_count_one", 32'(load_use_cnt), 32'd1);
    load_use_pattern(5'd0); step();
    idle(); step();

    // Mispredict wins over load-use.
    load_use_pattern(5'd5); mispredict = 1'b1; step();
    idle(); step();
    chk("flush_over_lu", {16'd0, 8'(flush_cnt), 8'(load_use_cnt)}, {16'd0, 8'd1, 8'd1});

    // Memory busy during mispredict, then the flush goes through.
    mispredict = 1'b1; dm_busy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    dm_busy = 1'b0; step();
    idle(); step();

    // Syscall drain with resume held in DRAIN (ignored), then resume in HALT.
    syscall_halt = 1'b1; step();
    idle(); resume = 1'b1; step(); step();
    chk("halted_after_drain", 32'(halted), 32'd1);
    step();
    idle(); step(); step();
    syscall_halt = 1'b1; step();
    idle(); step(); step(); step(); step();
    chk("halt_freeze", 32'(halted), 32'd1);
    resume = 1'b1; step();
    idle(); step();

    // Syscall with busy memory stretching the drain, then reset inside HALT.
    syscall_halt = 1'b1; step();
    idle(); dm_busy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    dm_busy = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("halted_before_reset", 32'(halted), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #1;
    rst_n = 1'b1;
    step();

    // Counter wrap: 16 plain RUN cycles.
    for (int i = 0; i < 16; i++) step();
    chk("cycle_wrap", 32'(cycle_cnt), 32'd1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_req_w     = 5'($urandom_range(0, 3));
      id_use_rs    = 1'($urandom_range(0, 1));
      id_use_rt    = 1'($urandom_range(0, 1));
      ex_r_datamem = 1'($urandom_range(0, 1));
      ex_w_en      = 1'($urandom_range(0, 3) != 0);
      mispredict   = ($urandom_range(0, 5) == 0);
      syscall_halt = ($urandom_range(0, 29) == 0);
      dm_busy      = ($urandom_range(0, 4) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      step();
    end

    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_sched.md
# hazard_sched

Pipeline hazard controller and scheduler for the five-stage core. Drives the enable and synchronous-clear inputs of the PC register and the four pipeline stage registers: PS1 (IF/ID), PS2 (ID/EX), PS3 (EX/MEM) and PS4 (MEM/WB). It resolves four events by fixed priority: data-memory busy, syscall halt, branch mispredict and load-use. It keeps a small halt/drain state machine and wrapping performance counters.

## Interface
- DRAIN_CYCLES, 2: cycles after a halting syscall leaves EX before the core freezes; legal range 1..15.
- CNT_W, 32: width of each performance counter.

- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs  in  5  source register A of the instruction in ID.
- id_rt  in  5  source register B of the instruction in ID.
- id_use_rs  in  1  the ID instruction reads id_rs.
- id_use_rt  in  1  the ID instruction reads id_rt.
- ex_r_datamem  in  1  the EX instruction is a load.
- ex_w_en  in  1  the EX instruction writes the register file.
- ex_req_w  in  5  destination register of the EX instruction.
- mispredict  in  1  the EX branch resolved differently from pc_guessed.
- syscall_halt  in  1  the EX instruction is a halting syscall.
- dm_busy  in  1  data memory cannot complete the MEM access this cycle.
- resume  in  1  single-cycle pulse that leaves HALT.
- pc_en  out  1  PC register enable.
- ps1_en, ps2_en, ps3_en, ps4_en  out  1 each  stage register enables.
- ps1_clear, ps2_clear  out  1 each  synchronous bubble insert into PS1 / PS2.
- halted  out  1  core is frozen in HALT.
- cycle_cnt, load_use_cnt, flush_cnt, mem_stall_cnt  out  CNT_W each  performance counters.

## Operation
- Control outputs are combinational from the current state and inputs. State, drain counter and perf counters are registered.
- Whenever a clear is 1, the same stage's enable is driven 0.
- Load-use hazard: `lu = ex_r_datamem & ex_w_en & (ex_req_w != 0) & ((id_use_rs & id_rs == ex_req_w) | (id_use_rt & id_rt == ex_req_w))`.
- States: RUN, DRAIN, HALT. Reset state is RUN.
- RUN, evaluated in priority order (the highest asserted event wins; lower events are ignored that cycle):
  1. dm_busy: all enables 0, clears 0; mem_stall_cnt++.
  2. syscall_halt: pc_en=0, ps1_clear=1, ps2_clear=1, ps3_en=ps4_en=1. Load drain counter with DRAIN_CYCLES-1 and go to DRAIN.
  3. mispredict: pc_en=1 (the external mux selects the corrected target), ps1_clear=1, ps2_clear=1, ps3_en=ps4_en=1; flush_cnt++.
  4. lu: pc_en=0, ps1_en=0, ps2_clear=1, ps3_en=ps4_en=1; load_use_cnt++.
  5. None: all enables 1, clears 0.
- DRAIN:
  - Normal cycle: pc_en=0, ps1_en=0, ps2_clear=1, ps3_en=ps4_en=1.
  - dm_busy: all enables 0 and clears 0 instead; the drain counter holds; mem_stall_cnt++.
  - Otherwise: when the counter is 0, go to HALT; else decrement it.
  - mispredict, lu, syscall_halt and resume are ignored.
- HALT:
  - All enables 0, clears 0, halted=1.
  - resume=1: go to RUN next edge (the first RUN cycle evaluates normally).
  - All other inputs are ignored.
- Counters:
  - cycle_cnt increments every cycle the state is not HALT.
  - All counters wrap modulo 2^CNT_W.

## Timing
- Reset: while rst_n=0, all enables 0, clears 0, halted 0, all counters 0, state RUN, drain counter 0. Reset mid-DRAIN or mid-HALT returns to RUN asynchronously.
- Control outputs have zero-cycle latency relative to the inputs. Stage registers act on the next rising edge.
- A load-use stall lasts exactly one cycle if the upstream inputs update normally: the bubble moves the load to MEM and lu deasserts.
- HALT is entered after the DRAIN phase: the syscall edge, then DRAIN_CYCLES DRAIN cycles not blocked by dm_busy. halted rises on the following cycle.
- The syscall itself advances into PS3 on the syscall edge. PS3/PS4 therefore drain it to writeback during DRAIN.
- resume asserted in the same cycle HALT is entered: ignored (still DRAIN). It is honoured only while in HALT.

## Test plan
- Load-use: ex_r_datamem=1, ex_w_en=1, ex_req_w=5, id_rs=5, id_use_rs=1 for one cycle -> pc_en=0, ps1_en=0, ps2_clear=1, ps3_en=1; load_use_cnt 0->1. Same stimulus with ex_req_w=0 -> no stall.
- Mispredict plus lu in the same cycle -> ps1_clear=ps2_clear=1, pc_en=1; flush_cnt=1, load_use_cnt=0.
- dm_busy=1 for 3 cycles during mispredict -> all enables 0, clears 0 for 3 cycles; mem_stall_cnt=3, flush_cnt increments once after dm_busy drops.
- syscall_halt pulse, DRAIN_CYCLES=2 -> 2 DRAIN cycles, then halted=1 and cycle_cnt frozen. resume pulse -> RUN, all enables 1 next cycle.
- syscall_halt, dm_busy=1 during DRAIN for 4 cycles, then rst_n pulsed low while in HALT -> DRAIN extended by 4 cycles; after reset, outputs are at reset values and state is RUN.
- Counter wrap with CNT_W=4: 16 RUN cycles -> cycle_cnt returns to 0.
